idu_pipe: RTL and testbench
===========================

IDU_PIPE -- requirements
Module: idu_pipe

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width.
REQ-002 Parameter NFWD, default 2, number of bypass sources; index 0 is the youngest (EX), 1 is MEM, and so on.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pc_i  in  32  PC of the instruction in ID.
REQ-006 inst_i  in  32  instruction word.
REQ-007 inst_valid_i  in  1  inst_i is meaningful.
REQ-008 reg1_addr_o, reg2_addr_o  out  5 each  regfile read addresses (rs, rt).
REQ-009 reg1_read_o, reg2_read_o  out  1 each  read enables.
REQ-010 reg1_data_i, reg2_data_i  in  DATA_W each  regfile read data.
REQ-011 fwd_wreg_i  in  NFWD  per-source write enable.
REQ-012 fwd_wd_i  in  5*NFWD  per-source destination address.
REQ-013 fwd_wdata_i  in  DATA_W*NFWD  per-source write data.
REQ-014 ex_is_load_i  in  1  the instruction in EX (source 0) is a load.
REQ-015 stall_i  in  1  downstream hold.
REQ-016 flush_i  in  1  kill the instruction in ID.
REQ-017 stallreq_o  out  1  combinational request to freeze PC/IF.
REQ-018 ex_aluop_o  out  8, ex_alusel_o  out  3, ex_reg1_o / ex_reg2_o  out  DATA_W, ex_wd_o  out  5, ex_wreg_o  out  1, ex_valid_o  out  1, ex_inv_o  out  1: registered ID/EX outputs.

Function
REQ-019 Decode set: AND, OR, XOR, NOR, SLLV, SRLV, SRAV, SLL, SRL, SRA, SYNC (SPECIAL, sa=0 for the R-logic and variable-shift ops); ORI, ANDI, XORI zero-extend imm16; LUI = OR of $0 with {imm16, 16'h0}; PREF = NOP.
REQ-020 Defaults for any instruction: aluop NOP, alusel NOP, wd=rd, wreg=0, read enables=0.
REQ-021 Unmatched opcode with inst_valid_i=1 SHALL set ex_inv_o=1, ex_wreg_o=0, ex_valid_o=1.
REQ-022 Immediate shifts: rt goes to operand 2, and sa zero-extended goes to operand 1.
REQ-023 Operand selection per port, in priority order:
- lowest-index fwd source with wreg=1, wd==addr, addr!=0, read=1;
- otherwise regfile data if read=1;
- otherwise the immediate.
REQ-024 Register 0 SHALL always read as zero and SHALL never be forwarded.
REQ-025 The ID/EX register SHALL update on the rising edge with this priority:
- flush_i: bubble;
- stall_i: hold;
- stallreq_o: bubble;
- otherwise: load decoded values.
REQ-026 Bubble = all ex_* outputs zero (ex_valid_o=0, ex_wreg_o=0).
REQ-027 inst_valid_i=0 SHALL load a bubble.
REQ-028 Decode-to-ex_* latency is exactly 1 cycle.
REQ-029 stallreq_o SHALL be masked while stall_i=1 and during rst.

Reset
REQ-030 rst=1 SHALL immediately clear all ex_* outputs to zero, without waiting for a clock edge.
REQ-031 rst=1 SHALL drive stallreq_o=0, read enables=0, and read addresses=0.
REQ-032 The first load after rst deasserts SHALL occur on the next clk edge.

Configuration
REQ-033 With IDU_LOAD_INTERLOCK_EN defined, stallreq_o SHALL equal inst_valid_i & ex_is_load_i & fwd_wreg_i[0] & (fwd_wd_i[0] matches an enabled nonzero read address). It lasts one cycle, because the load then sits at source 1 and is forwarded.
REQ-034 With IDU_LOAD_INTERLOCK_EN undefined, stallreq_o SHALL be tied to 0, ex_is_load_i SHALL be ignored, and EX data is forwarded unconditionally.

Structure
REQ-035 A shared package/defines SHALL hold:
- opcode and funct constants;
- the AluOp and AluSel encodings;
- the NOP register address;
- widths for AluOpBus, AluSelBus and RegAddrBus.
REQ-036 One sub-module, idu_fwd_mux, SHALL be instantiated twice; it implements the REQ-023 priority selection for one operand.
REQ-037 All state SHALL be the ID/EX register only; there is no other FSM.

Verification
REQ-038 ORI $1,$0,0x1100 -> next cycle: ex_reg1_o=0, ex_reg2_o=0x00001100, ex_wd_o=1, ex_wreg_o=1, aluop=OR.
REQ-039 fwd0 (wd=3, data 0xAAAA) and fwd1 (wd=3, data 0x5555) both active; AND $4,$3,$3 -> both operands 0xAAAA.
REQ-040 fwd0 writes $0 with 0xFFFF; OR $5,$0,$0 -> operands 0 (no forward).
REQ-041 With the macro defined: ex_is_load_i=1, fwd0 wd=2; OR $6,$2,$7 -> stallreq_o=1 for one cycle and a bubble, then operand 1 comes from fwd1.
- Without the macro: stallreq_o=0 and no bubble.
REQ-042 Simultaneous stall_i and flush_i -> bubble.
- stall_i alone for 3 cycles -> ex_* held constant.
REQ-043 rst asserted mid-stream between clock edges -> ex_* reach 0 before the next edge; opcode 0x3F -> ex_inv_o=1.

Source files
------------

// File: rtl/idu_pipe_pkg.sv
// Shared decode constants for the ID stage: opcodes, functs, ALU encodings and bus widths.
package idu_pipe_pkg;

  localparam int unsigned AluOpBus   = 8;
  localparam int unsigned AluSelBus  = 3;
  localparam int unsigned RegAddrBus = 5;

  localparam logic [RegAddrBus-1:0] RegNop = '0;

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpAndi    = 6'b001100;
  localparam logic [5:0] OpOri     = 6'b001101;
  localparam logic [5:0] OpXori    = 6'b001110;
  localparam logic [5:0] OpLui     = 6'b001111;
  localparam logic [5:0] OpPref    = 6'b110011;

  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSllv = 6'b000100;
  localparam logic [5:0] FnSrlv = 6'b000110;
  localparam logic [5:0] FnSrav = 6'b000111;
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSra  = 6'b000011;
  localparam logic [5:0] FnSync = 6'b001111;

  localparam logic [AluOpBus-1:0] AluOpNop = 8'b00000000;
  localparam logic [AluOpBus-1:0] AluOpAnd = 8'b00100100;
  localparam logic [AluOpBus-1:0] AluOpOr  = 8'b00100101;
  localparam logic [AluOpBus-1:0] AluOpXor = 8'b00100110;
  localparam logic [AluOpBus-1:0] AluOpNor = 8'b00100111;
  localparam logic [AluOpBus-1:0] AluOpSll = 8'b01111100;
  localparam logic [AluOpBus-1:0] AluOpSrl = 8'b00000010;
  localparam logic [AluOpBus-1:0] AluOpSra = 8'b00000011;

  localparam logic [AluSelBus-1:0] AluSelNop   = 3'b000;
  localparam logic [AluSelBus-1:0] AluSelLogic = 3'b001;
  localparam logic [AluSelBus-1:0] AluSelShift = 3'b010;

endpackage

// File: rtl/idu_pipe_fwd_mux.sv
// Operand select for one read port: youngest matching bypass, then regfile, then immediate.
module idu_fwd_mux
  import idu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NFWD   = 2
) (
  input  logic                   read,
  input  logic [RegAddrBus-1:0]  addr,
  input  logic [DATA_W-1:0]      rf_data,
  input  logic [DATA_W-1:0]      imm,
  input  logic [NFWD-1:0]        fwd_wreg,
  input  logic [5*NFWD-1:0]      fwd_wd,
  input  logic [DATA_W*NFWD-1:0] fwd_wdata,
  output logic [DATA_W-1:0]      data
);

  always_comb begin
    data = imm;
    if (read) begin
      if (addr == RegNop) begin
        data = '0;
      end else begin
        data = rf_data;
        // Walk oldest to youngest so the lowest index wins.
        for (int i = NFWD - 1; i >= 0; i--) begin
          if (fwd_wreg[i] && (fwd_wd[i*5 +: 5] == addr)) begin
            data = fwd_wdata[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/idu_pipe.sv
// Instruction decode stage with operand bypass and the ID/EX pipeline register.
// Optional load-use interlock enabled by defining IDU_LOAD_INTERLOCK_EN.
module idu_pipe
  import idu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NFWD   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            pc_i,
  input  logic [31:0]            inst_i,
  input  logic                   inst_valid_i,
  output logic [RegAddrBus-1:0]  reg1_addr_o,
  output logic [RegAddrBus-1:0]  reg2_addr_o,
  output logic                   reg1_read_o,
  output logic                   reg2_read_o,
  input  logic [DATA_W-1:0]      reg1_data_i,
  input  logic [DATA_W-1:0]      reg2_data_i,
  input  logic [NFWD-1:0]        fwd_wreg_i,
  input  logic [5*NFWD-1:0]      fwd_wd_i,
  input  logic [DATA_W*NFWD-1:0] fwd_wdata_i,
  input  logic                   ex_is_load_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic                   stallreq_o,
  output logic [AluOpBus-1:0]    ex_aluop_o,
  output logic [AluSelBus-1:0]   ex_alusel_o,
  output logic [DATA_W-1:0]      ex_reg1_o,
  output logic [DATA_W-1:0]      ex_reg2_o,
  output logic [RegAddrBus-1:0]  ex_wd_o,
  output logic                   ex_wreg_o,
  output logic                   ex_valid_o,
  output logic                   ex_inv_o
);

  localparam int ExW = AluOpBus + AluSelBus + 2 * DATA_W + RegAddrBus + 3;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm16 = inst_i[15:0];

  logic [AluOpBus-1:0]   d_aluop;
  logic [AluSelBus-1:0]  d_alusel;
  logic [RegAddrBus-1:0] d_wd;
  logic                  d_wreg, d_inv, r1_read, r2_read;
  logic [DATA_W-1:0]     imm1, imm2, op1, op2;

  always_comb begin
    d_aluop  = AluOpNop;
    d_alusel = AluSelNop;
    d_wd     = rd;
    d_wreg   = 1'b0;
    d_inv    = 1'b0;
    r1_read  = 1'b0;
    r2_read  = 1'b0;
    imm1     = '0;
    imm2     = '0;
    case (op)
      OpSpecial: begin
        case (funct)
          FnAnd, FnOr, FnXor, FnNor: begin
            if (sa == 5'd0) begin
              d_alusel = AluSelLogic;
              d_wreg   = 1'b1;
              r1_read  = 1'b1;
              r2_read  = 1'b1;
              case (funct)
                FnAnd:   d_aluop = AluOpAnd;
                FnOr:    d_aluop = AluOpOr;
                FnXor:   d_aluop = AluOpXor;
                default: d_aluop = AluOpNor;
              endcase
            end else begin
              d_inv = 1'b1;
            end
          end
          FnSllv, FnSrlv, FnSrav: begin
            if (sa == 5'd0) begin
              d_alusel = AluSelShift;
              d_wreg   = 1'b1;
              r1_read  = 1'b1;
              r2_read  = 1'b1;
              case (funct)
                FnSllv:  d_aluop = AluOpSll;
                FnSrlv:  d_aluop = AluOpSrl;
                default: d_aluop = AluOpSra;
              endcase
            end else begin
              d_inv = 1'b1;
            end
          end
          FnSll, FnSrl, FnSra: begin
            // Shift amount rides in operand 1 so the ALU sees the same layout as xxxV.
            d_alusel = AluSelShift;
            d_wreg   = 1'b1;
            r2_read  = 1'b1;
            imm1     = DATA_W'(sa);
            case (funct)
              FnSll:   d_aluop = AluOpSll;
              FnSrl:   d_aluop = AluOpSrl;
              default: d_aluop = AluOpSra;
            endcase
          end
          FnSync:  ;
          default: d_inv = 1'b1;
        endcase
      end
      OpOri, OpAndi, OpXori: begin
        d_alusel = AluSelLogic;
        d_wd     = rt;
        d_wreg   = 1'b1;
        r1_read  = 1'b1;
        imm2     = DATA_W'(imm16);
        case (op)
          OpOri:   d_aluop = AluOpOr;
          OpAndi:  d_aluop = AluOpAnd;
          default: d_aluop = AluOpXor;
        endcase
      end
      OpLui: begin
        d_aluop  = AluOpOr;
        d_alusel = AluSelLogic;
        d_wd     = rt;
        d_wreg   = 1'b1;
        imm2     = DATA_W'({imm16, 16'h0000});
      end
      OpPref:  ;
      default: d_inv = 1'b1;
    endcase
  end

  assign reg1_addr_o = rst ? RegNop : rs;
  assign reg2_addr_o = rst ? RegNop : rt;
  assign reg1_read_o = !rst && r1_read;
  assign reg2_read_o = !rst && r2_read;

  idu_fwd_mux #(.DATA_W(DATA_W), .NFWD(NFWD)) u_fwd1 (
    .read(reg1_read_o), .addr(reg1_addr_o), .rf_data(reg1_data_i), .imm(imm1),
    .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i), .data(op1)
  );

  idu_fwd_mux #(.DATA_W(DATA_W), .NFWD(NFWD)) u_fwd2 (
    .read(reg2_read_o), .addr(reg2_addr_o), .rf_data(reg2_data_i), .imm(imm2),
    .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i), .data(op2)
  );

  logic unused_inputs;
`ifdef IDU_LOAD_INTERLOCK_EN
  logic hit1, hit2;
  assign hit1 = reg1_read_o && (reg1_addr_o != RegNop) && (fwd_wd_i[4:0] == reg1_addr_o);
  assign hit2 = reg2_read_o && (reg2_addr_o != RegNop) && (fwd_wd_i[4:0] == reg2_addr_o);
  assign stallreq_o = !rst && !stall_i && inst_valid_i && ex_is_load_i && fwd_wreg_i[0] &&
                      (hit1 || hit2);
  assign unused_inputs = ^pc_i;
`else
  assign stallreq_o    = 1'b0;
  assign unused_inputs = ^{pc_i, ex_is_load_i};
`endif

  logic [ExW-1:0] ex_q, ex_d;
  assign ex_d = {d_aluop, d_alusel, op1, op2, d_wd, d_wreg, 1'b1, d_inv};
  assign {ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_valid_o,
          ex_inv_o} = ex_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (flush_i) begin
      ex_q <= '0;
    end else if (!stall_i) begin
      ex_q <= (stallreq_o || !inst_valid_i) ? '0 : ex_d;
    end
  end

endmodule

// File: tb/tb_idu_pipe.sv
// Self-checking bench for idu_pipe: vector table through a scoreboard plus multi-cycle sequences.
module tb_idu_pipe;
  import idu_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, inst_i;
  logic        inst_valid_i;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic        reg1_read_o, reg2_read_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic [1:0]  fwd_wreg_i;
  logic [9:0]  fwd_wd_i;
  logic [63:0] fwd_wdata_i;
  logic        ex_is_load_i, stall_i, flush_i, stallreq_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [31:0] ex_reg1_o, ex_reg2_o;
  logic [4:0]  ex_wd_o;
  logic        ex_wreg_o, ex_valid_o, ex_inv_o;

  idu_pipe #(.DATA_W(32), .NFWD(2)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .ex_is_load_i(ex_is_load_i), .stall_i(stall_i), .flush_i(flush_i),
    .stallreq_o(stallreq_o), .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
    .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o),
    .ex_wreg_o(ex_wreg_o), .ex_valid_o(ex_valid_o), .ex_inv_o(ex_inv_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic        valid;
    logic        inv;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        vld;
    logic [31:0] rf1, rf2;
    logic [1:0]  fwreg;
    logic [4:0]  wd0, wd1;
    logic [31:0] fd0, fd1;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t mk(input logic [7:0] aluop, input logic [2:0] alusel,
                              input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd,
                              input logic wreg, input logic valid, input logic inv);
    mk = {aluop, alusel, r1, r2, wd, wreg, valid, inv};
  endfunction

  task automatic add(input string name, input logic [31:0] inst, input logic vld,
                     input logic [31:0] rf1, input logic [31:0] rf2, input logic [1:0] fwreg,
                     input logic [4:0] wd0, input logic [4:0] wd1, input logic [31:0] fd0,
                     input logic [31:0] fd1, input exp_t e);
    vec_t v;
    v.name = name; v.inst = inst; v.vld = vld; v.rf1 = rf1; v.rf2 = rf2; v.fwreg = fwreg;
    v.wd0 = wd0; v.wd1 = wd1; v.fd0 = fd0; v.fd1 = fd1; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] inst, input logic vld, input logic [31:0] rf1,
                       input logic [31:0] rf2, input logic [1:0] fwreg, input logic [4:0] wd0,
                       input logic [4:0] wd1, input logic [31:0] fd0, input logic [31:0] fd1);
    inst_i = inst; inst_valid_i = vld; reg1_data_i = rf1; reg2_data_i = rf2;
    fwd_wreg_i = fwreg; fwd_wd_i = {wd1, wd0}; fwd_wdata_i = {fd1, fd0};
  endtask

  task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Waits for the edge, then compares ex_* against the oldest scoreboard entry.
  task automatic tick(input string name);
    exp_t a, e;
    @(posedge clk);
    #1;
    a = {ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_valid_o,
         ex_inv_o};
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", name, a);
    end else begin
      e = q.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got op=%h sel=%h r1=%h r2=%h wd=%0d wreg=%b v=%b inv=%b",
                 name, a.aluop, a.alusel, a.r1, a.r2, a.wd, a.wreg, a.valid, a.inv);
        $display("     %s: want op=%h sel=%h r1=%h r2=%h wd=%0d wreg=%b v=%b inv=%b",
                 name, e.aluop, e.alusel, e.r1, e.r2, e.wd, e.wreg, e.valid, e.inv);
      end
    end
    @(negedge clk);
  endtask

  localparam logic [31:0] InstOri  = 32'h34011100;  // ORI $1,$0,0x1100
  localparam logic [31:0] InstXor  = 32'h01093826;  // XOR $7,$8,$9
  localparam logic [31:0] InstOrLd = 32'h00473025;  // OR $6,$2,$7

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t ori_e, ld_e;
    logic exp_req;
    ori_e = mk(AluOpOr, AluSelLogic, 32'h0, 32'h00001100, 5'd1, 1'b1, 1'b1, 1'b0);
    ld_e  = mk(AluOpOr, AluSelLogic, 32'h1111, 32'h7777, 5'd6, 1'b1, 1'b1, 1'b0);

    add("ori", InstOri, 1, 32'hDEAD, 32'hBEEF, 2'b00, 0, 0, 0, 0, ori_e);
    add("and_fwd_prio", 32'h00632024, 1, 32'h1, 32'h2, 2'b11, 3, 3, 32'hAAAA, 32'h5555,
        mk(AluOpAnd, AluSelLogic, 32'hAAAA, 32'hAAAA, 5'd4, 1, 1, 0));
    add("or_r0_nofwd", 32'h00002825, 1, 32'h1234, 32'h1234, 2'b01, 0, 0, 32'hFFFF, 0,
        mk(AluOpOr, AluSelLogic, 32'h0, 32'h0, 5'd5, 1, 1, 0));
    add("xor_rf", InstXor, 1, 32'h0F0F0000, 32'h12345678, 2'b00, 8, 9, 32'h1, 32'h2,
        mk(AluOpXor, AluSelLogic, 32'h0F0F0000, 32'h12345678, 5'd7, 1, 1, 0));
    add("nor_fwd1", 32'h016C5027, 1, 32'h11111111, 32'h22222222, 2'b10, 11, 12, 32'h3, 32'hCAFE,
        mk(AluOpNor, AluSelLogic, 32'h11111111, 32'hCAFE, 5'd10, 1, 1, 0));
    add("sll_imm", 32'h00031140, 1, 32'h9, 32'hF, 2'b00, 0, 0, 0, 0,
        mk(AluOpSll, AluSelShift, 32'd5, 32'hF, 5'd2, 1, 1, 0));
    add("srl_fwd0", 32'h000527C2, 1, 32'h9, 32'h1, 2'b01, 5, 0, 32'hF0000000, 0,
        mk(AluOpSrl, AluSelShift, 32'd31, 32'hF0000000, 5'd4, 1, 1, 0));
    add("srav", 32'h01073007, 1, 32'h4, 32'h80000000, 2'b00, 0, 0, 0, 0,
        mk(AluOpSra, AluSelShift, 32'h4, 32'h80000000, 5'd6, 1, 1, 0));
    add("lui", 32'h3C09ABCD, 1, 32'h77, 32'h88, 2'b00, 0, 0, 0, 0,
        mk(AluOpOr, AluSelLogic, 32'h0, 32'hABCD0000, 5'd9, 1, 1, 0));
    add("andi_zext", 32'h3083FFFF, 1, 32'h12345678, 32'h0, 2'b00, 0, 0, 0, 0,
        mk(AluOpAnd, AluSelLogic, 32'h12345678, 32'h0000FFFF, 5'd3, 1, 1, 0));
    add("xori_fwd", 32'h38418000, 1, 32'h5, 32'h6, 2'b11, 2, 2, 32'h99, 32'h77,
        mk(AluOpXor, AluSelLogic, 32'h99, 32'h8000, 5'd1, 1, 1, 0));
    add("op3f_inv", 32'hFC221234, 1, 32'h5, 32'h6, 2'b00, 0, 0, 0, 0,
        mk(AluOpNop, AluSelNop, 32'h0, 32'h0, 5'd2, 0, 1, 1));
    add("and_sa_inv", 32'h00632064, 1, 32'h5, 32'h6, 2'b00, 0, 0, 0, 0,
        mk(AluOpNop, AluSelNop, 32'h0, 32'h0, 5'd4, 0, 1, 1));
    add("sync", 32'h0000000F, 1, 32'h5, 32'h6, 2'b00, 0, 0, 0, 0,
        mk(AluOpNop, AluSelNop, 32'h0, 32'h0, 5'd0, 0, 1, 0));
    add("pref", 32'hCC000000, 1, 32'h5, 32'h6, 2'b00, 0, 0, 0, 0,
        mk(AluOpNop, AluSelNop, 32'h0, 32'h0, 5'd0, 0, 1, 0));
    add("invalid_bubble", InstOri, 0, 32'h5, 32'h6, 2'b00, 0, 0, 0, 0, exp_t'(0));

    // Reset state with a live instruction on the inputs.
    rst = 1'b1; stall_i = 0; flush_i = 0; ex_is_load_i = 0; pc_i = 32'h100;
    drive(InstXor, 1, 32'h1, 32'h2, 2'b00, 0, 0, 0, 0);
    #2;
    check_val("rst_ex", {ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
                         ex_valid_o, ex_inv_o}, 0);
    check_val("rst_rd", {reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stallreq_o}, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].inst, vecs[i].vld, vecs[i].rf1, vecs[i].rf2, vecs[i].fwreg,
            vecs[i].wd0, vecs[i].wd1, vecs[i].fd0, vecs[i].fd1);
      q.push_back(vecs[i].e);
      #1;
      check_val({vecs[i].name, "_addr"}, {reg1_addr_o, reg2_addr_o},
                {vecs[i].inst[25:21], vecs[i].inst[20:16]});
      tick(vecs[i].name);
    end

    // Stall holds ex_* for three cycles while ID shows something else.
    drive(InstOri, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    q.push_back(ori_e);
    tick("hold_load");
    stall_i = 1;
    drive(InstXor, 1, 32'h3, 32'h4, 2'b00, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      q.push_back(ori_e);
      tick("stall_hold");
    end
    flush_i = 1;
    q.push_back(exp_t'(0));
    tick("stall_flush");
    stall_i = 0;
    drive(InstOri, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    q.push_back(exp_t'(0));
    tick("flush_only");
    flush_i = 0;
    q.push_back(ori_e);
    tick("after_flush");

    // Load-use on rs from EX.
`ifdef IDU_LOAD_INTERLOCK_EN
    exp_req = 1'b1;
`else
    exp_req = 1'b0;
`endif
    ex_is_load_i = 1;
    drive(InstOrLd, 1, 32'hBAD, 32'h7777, 2'b01, 2, 0, 32'h1111, 0);
    #1;
    check_val("ld_stallreq", stallreq_o, exp_req);
    q.push_back(exp_req ? exp_t'(0) : ld_e);
    tick("ld_first");
    ex_is_load_i = 0;
    drive(InstOrLd, 1, 32'hBAD, 32'h7777, 2'b10, 0, 2, 0, 32'h1111);
    #1;
    check_val("ld_stallreq_clear", stallreq_o, 0);
    q.push_back(ld_e);
    tick("ld_second");
    stall_i = 1;
    ex_is_load_i = 1;
    drive(InstOrLd, 1, 32'hBAD, 32'h7777, 2'b01, 2, 0, 32'h1111, 0);
    #1;
    check_val("ld_stallreq_masked", stallreq_o, 0);
    q.push_back(ld_e);
    tick("ld_masked_hold");
    stall_i = 0;
    ex_is_load_i = 0;

    // Asynchronous reset between edges, then first load on the next edge.
    drive(InstOri, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    q.push_back(ori_e);
    tick("pre_rst");
    drive(InstXor, 1, 32'h1, 32'h2, 2'b00, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_ex", {ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o,
                               ex_wreg_o, ex_valid_o, ex_inv_o}, 0);
    check_val("async_rst_rd", {reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o,
                               stallreq_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(InstOri, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    q.push_back(ori_e);
    tick("first_after_rst");

    check_val("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
